// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared state encoding and default width for piso_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  localparam int PISO_DEFAULT_WIDTH = 16;

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_if
// Description : Load handshake plus serial stream bundle for piso_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_if
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output load_data, load_valid,
    input  load_ready, serial_out, serial_valid, busy, frame_done
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, serial_out, serial_valid, busy, frame_done
  );

endinterface : piso_serializer_if
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : MSB-first parallel-to-serial stage feeding moore_machine.
//               Define PISO_PARITY_EN to append an even-parity bit per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  piso_serializer_if.slave   bus
);

  localparam int               CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  piso_state_t      state_q,   state_d;
  logic [WIDTH-1:0] shift_q,   shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
`ifdef PISO_PARITY_EN
  logic             parity_q,  parity_d;
`endif

  logic last_bit;
  logic accept;

  always_comb begin
    last_bit = (state_q == SHIFT) && (bit_cnt_q == '0);

`ifdef PISO_PARITY_EN
    bus.load_ready = rst_n && ((state_q == IDLE) || (state_q == PARITY));
`else
    bus.load_ready = rst_n && ((state_q == IDLE) || last_bit);
`endif
    accept = bus.load_valid && bus.load_ready;

    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef PISO_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: ;
      SHIFT: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end else begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    // A new word overrides the end-of-frame return to IDLE for zero-bubble chaining.
    if (accept) begin
      state_d   = SHIFT;
      shift_d   = bus.load_data;
      bit_cnt_d = C_LAST;
`ifdef PISO_PARITY_EN
      parity_d  = ^bus.load_data;
`endif
    end
  end

  always_comb begin
    bus.serial_out   = 1'b0;
    bus.serial_valid = 1'b0;
    bus.busy         = 1'b0;
    bus.frame_done   = 1'b0;
    case (state_q)
      SHIFT: begin
        bus.serial_out   = shift_q[WIDTH-1];
        bus.serial_valid = 1'b1;
        bus.busy         = 1'b1;
`ifndef PISO_PARITY_EN
        bus.frame_done   = rst_n && last_bit;
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        bus.serial_out   = parity_q;
        bus.serial_valid = 1'b1;
        bus.busy         = 1'b1;
        bus.frame_done   = rst_n;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef PISO_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef PISO_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

`ifndef SYNTHESIS
  a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == SHIFT) |-> (bit_cnt_q <= C_LAST));
`endif

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Scoreboard bench for piso_serializer (honours PISO_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int W = 16;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_LEN = W + PAR;

  typedef struct {
    logic b;
    logic done;
  } exp_t;

  logic clk;
  logic rst_n;
  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   run = 0;
  int   last_run = 0;
  int   fd_count = 0;
  int   frames_sent = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference: a word becomes its bits MSB first, optionally followed by even parity.
  task automatic push_frame(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      exp_q.push_back('{b: w[i], done: (PAR == 0) && (i == 0)});
    end
    if (PAR != 0) exp_q.push_back('{b: ^w, done: 1'b1});
    frames_sent++;
  endtask

  // Monitor: pop one expected bit for every valid serial cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      run = 0;
    end else if (bus.serial_valid) begin
      run++;
      if (bus.frame_done) fd_count++;
      if (exp_q.size() == 0) begin
        flag("unexpected_serial_bit");
      end else begin
        e = exp_q.pop_front();
        chk("serial_out", bus.serial_out, e.b);
        chk("frame_done", bus.frame_done, e.done);
        chk("busy", bus.busy, 1);
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
      chk("idle_serial_out", bus.serial_out, 0);
      chk("idle_frame_done", bus.frame_done, 0);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    bus.load_data  = w;
    bus.load_valid = 1'b1;
    while (!bus.load_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.load_ready) begin
      flag("send_timeout");
      bus.load_valid = 1'b0;
      return;
    end
    push_frame(w);
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.load_data  = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.serial_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || bus.serial_valid) flag("drain_timeout");
    @(negedge clk);
    chk("state_idle_after_frame", dut.state_q, IDLE);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int fd0;
    logic [W-1:0] w;

    // Reset held with load_valid high: nothing may be accepted.
    rst_n          = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = W'($urandom);
    repeat (2) begin
      @(negedge clk);
      chk("rst_serial_valid", bus.serial_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_load_ready", bus.load_ready, 0);
      chk("rst_serial_out", bus.serial_out, 0);
      chk("rst_frame_done", bus.frame_done, 0);
    end
    chk("rst_state", dut.state_q, IDLE);
    bus.load_valid = 1'b0;
    rst_n          = 1'b1;
    @(negedge clk);
    chk("idle_load_ready", bus.load_ready, 1);
    chk("idle_serial_valid", bus.serial_valid, 0);

    // Single word.
    fd0 = fd_count;
    send(16'b0101101010110101);
    drain();
    chk("single_run_len", last_run, FRAME_LEN);
    chk("single_frame_done_cnt", fd_count - fd0, 1);

    // Back-to-back frames with load_valid held.
    fd0 = fd_count;
    send(16'hFFFF);
    send(16'h0000);
    drain();
    chk("b2b_run_len", last_run, 2 * FRAME_LEN);
    chk("b2b_frame_done_cnt", fd_count - fd0, 2);

    // Mid-frame load pulse must be dropped.
    fd0 = fd_count;
    send(W'($urandom));
    repeat (4) @(negedge clk);
    bus.load_data  = 16'hAAAA;
    bus.load_valid = 1'b1;
    chk("midframe_load_ready", bus.load_ready, 0);
    @(negedge clk);
    bus.load_valid = 1'b0;
    drain();
    chk("midframe_run_len", last_run, FRAME_LEN);
    chk("midframe_frame_done_cnt", fd_count - fd0, 1);

    // Reset at bit 8 aborts the frame.
    fd0 = fd_count;
    send(W'($urandom));
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 exp_q.delete();
    frames_sent--;
    @(negedge clk);
    chk("abort_serial_valid", bus.serial_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_frame_done", bus.frame_done, 0);
    chk("abort_serial_out", bus.serial_out, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_frame_done_cnt", fd_count - fd0, 0);
    fd0 = fd_count;
    send(W'($urandom));
    drain();
    chk("post_abort_run_len", last_run, FRAME_LEN);
    chk("post_abort_frame_done_cnt", fd_count - fd0, 1);

    // Parity corner words (plain frames when parity is disabled).
    send(16'h0007);
    drain();
    send(16'h0003);
    drain();

    // Randomised words with random gaps, including zero-gap chains.
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w = W'($urandom);
      send(w);
    end
    drain();
    chk("total_frames", fd_count, frames_sent);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_piso_serializer
`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of moore_machine.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clk, on serial_out.
- serial_out connects straight to moore_machine data_in, so test patterns and live data reach the sequence detector as a gap-free bit stream.

Parameters:
WIDTH, 16, data bits per word (legal range 2..64).
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
load_data  input  WIDTH  parallel word to serialize.
load_valid  input  1  load_data is valid this cycle.
load_ready  output  1  serializer can accept a word this cycle.
serial_out  output  1  serial bit stream (to moore_machine data_in).
serial_valid  output  1  serial_out carries a frame bit this cycle.
busy  output  1  frame in progress.
frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.

Behaviour:
- Reset (rst_n==0 at a rising edge):
  - state=IDLE; shift_reg=0; bit_cnt=0.
  - serial_out=0, serial_valid=0, busy=0, frame_done=0, load_ready=1 (load_ready is combinational and is forced 0 while rst_n==0).
- States: IDLE, SHIFT (plus PARITY with the optional feature). Use a 2-bit enum.
- Handshake: a word is accepted on a rising edge where load_valid && load_ready. load_data is sampled only then; it is ignored at all other times.
- load_ready = (state==IDLE) || (state==SHIFT && bit_cnt==0 && no parity pending). This allows back-to-back frames with zero bubble.
- On acceptance:
  - shift_reg <= load_data; bit_cnt <= WIDTH-1; state <= SHIFT.
  - First bit (load_data[WIDTH-1]) appears on serial_out in the cycle after acceptance, so accept-to-first-bit latency is 1 cycle.
- SHIFT:
  - serial_out = shift_reg[WIDTH-1] (registered); serial_valid=1; busy=1.
  - Each edge: shift_reg shifts left by 1 (zero fill); bit_cnt decrements.
  - When bit_cnt==0: frame_done=1 for that cycle. Next state is SHIFT with the new word if one is accepted, otherwise IDLE.
- IDLE: serial_out=0 (holds moore_machine in S0-safe input), serial_valid=0, busy=0.
- bit_cnt never wraps; decrement below 0 is unreachable by construction. An assertion covers this.
- A load_valid pulse mid-frame (load_ready==0) is dropped. The upstream source must hold load_valid until accepted.
- Reset mid-frame: the frame is aborted; the next cycle shows serial_out=0 and serial_valid=0, and no frame_done is emitted.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra cycle in state PARITY drives serial_out = ^word (even parity) with serial_valid=1.
  - frame_done moves to the parity cycle. load_ready is asserted in the parity cycle, not on the last data bit.
  - Frame length is WIDTH+1 cycles.
  - Parity is computed and registered at acceptance.
- Undefined: the PARITY state and parity register are absent; frame length is WIDTH cycles.

Decomposition:
- Package piso_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, PARITY} piso_state_t.
  - localparam PISO_DEFAULT_WIDTH = 16.
- Single module; no sub-module warranted.
- The bench reuses the package enum for state checks via hierarchical reference.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with load_valid=1 -> serial_valid=0, busy=0, load_ready=0, serial_out=0 throughout; no word accepted.
- Single word: load 16'b0101101010110101 -> serial_out over cycles 1..16 reads 0,1,0,1,1,0,1,0,1,0,1,1,0,1,0,1; frame_done high only on cycle 16; IDLE on cycle 17.
- Back-to-back: hold load_valid=1 with 16'hFFFF then 16'h0000 -> 32 consecutive serial_valid=1 cycles (16 ones, then 16 zeros); frame_done on cycles 16 and 32.
- Mid-frame load: pulse load_valid for 1 cycle at bit 5 with 16'hAAAA -> pulse ignored; current frame completes unchanged; no second frame.
- Reset mid-frame: assert rst_n=0 at bit 8 -> next cycle serial_valid=0, busy=0, no frame_done; a new load afterwards serializes correctly from its MSB.
- PISO_PARITY_EN: load 16'b0000000000000111 -> 16 data bits then parity bit 1 on cycle 17, with frame_done on cycle 17. Load 16'h0003 -> parity bit 0.
